ps2_rx: RTL and testbench
=========================

PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8, number of consecutive equal ps2c samples needed to change the filtered clock level.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000, number of clk cycles without a filtered falling edge before an in-progress frame is aborted.
REQ-003 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-004 reset  input  1  reset; synchronous to clk and active-high.
REQ-005 rx_en  input  1  receive enable; gates only the acceptance of a new start bit.
REQ-006 ps2d  input  1  PS/2 data line, asynchronous, idle high.
REQ-007 ps2c  input  1  PS/2 clock line, asynchronous, idle high, approximately 10-16.7 kHz.
REQ-008 rx_done_tick  output  1  single-cycle strobe marking a valid received byte.
REQ-009 rx_data  output  8  last valid received byte.

Function
REQ-010 ps2c and ps2d SHALL each pass through a 2-flop synchronizer before any other use.
REQ-011 The synchronized ps2c SHALL feed a FILTER_LEN-bit shift register; the filtered clock SHALL go to 1 when all bits are 1, go to 0 when all bits are 0, and otherwise hold.
REQ-012 A falling edge SHALL be a single-cycle event, flagged when the filtered clock was 1 in the previous cycle and is 0 in the current cycle; glitches shorter than FILTER_LEN cycles SHALL produce no edge.
REQ-013 Frame format: 11 bits (start=0, data[0] to data[7] LSB first, odd parity, stop=1), each sampled from synchronized ps2d in the cycle its falling edge is flagged.
REQ-014 FSM states SHALL be IDLE, RECV and DONE.
REQ-015 IDLE to RECV: on a falling edge with rx_en=1 and ps2d=0, with the bit counter loaded to 10; in all other cases the FSM SHALL stay in IDLE.
REQ-016 RECV: each falling edge SHALL shift the sampled bit in and decrement the counter; the edge that samples the stop bit (counter 0) SHALL trigger the frame check.
REQ-017 Frame check: when the stop bit is 1 and data plus parity contain an odd number of ones, the FSM SHALL go to DONE; otherwise it SHALL discard the frame silently and go to IDLE.
REQ-018 DONE SHALL last exactly one cycle and then return to IDLE; rx_done_tick SHALL be 1 only in DONE.
REQ-019 rx_data SHALL be loaded in the same cycle rx_done_tick is 1, and SHALL hold its value until the next valid frame.
REQ-020 Latency: rx_done_tick SHALL rise on the clk cycle immediately after the cycle in which the stop-bit falling edge is flagged.
REQ-021 rx_en SHALL be ignored once in RECV, so a started frame always completes or is discarded.
REQ-022 The timeout counter SHALL count in RECV and clear on every falling edge; on reaching TIMEOUT_CYCLES the FSM SHALL abort to IDLE with no tick and rx_data unchanged.
REQ-023 Back-to-back frames SHALL be received with no dead time beyond the DONE cycle.

Reset
REQ-024 On reset the FSM SHALL be in IDLE and all counters SHALL be 0.
REQ-025 On reset rx_done_tick SHALL be 0 and rx_data SHALL be 8'h00.
REQ-026 On reset the synchronizers and the filter shift register SHALL be all 1s and the filtered clock SHALL be 1, so no spurious edge is flagged after reset.
REQ-027 Reset asserted mid-frame SHALL drop the partial frame, and the next tick SHALL come only from a complete new frame.

Verification
REQ-028 Send 0xF0 (parity 1, stop 1) with rx_en=1 -> exactly one rx_done_tick, rx_data=8'hF0.
REQ-029 Send 0x12, then 0x1C (parity 0) back-to-back -> two ticks, rx_data=8'h12, then 8'h1C.
REQ-030 Send 0x12 with parity bit 0 or stop bit 0 -> no tick, rx_data keeps its previous value.
REQ-031 Hold rx_en=0 and send 0x1C -> no tick; set rx_en=1 mid-frame -> no tick for that frame; the next full frame is received.
REQ-032 Inject a ps2c low glitch of FILTER_LEN-1 cycles in IDLE, then a valid 0x5A -> a single tick with rx_data=8'h5A.
REQ-033 Stop ps2c after 5 bits for TIMEOUT_CYCLES -> return to IDLE with no tick; a following 0xF0 frame is received; reset asserted mid-frame -> outputs 0 and no tick.

Source files
------------

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver.
// Synchronizes and filters ps2c, then frames 11-bit words with parity check.
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_en,
  input  logic       ps2d,
  input  logic       ps2c,
  output logic       rx_done_tick,
  output logic [7:0] rx_data
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);

  logic                  r_ps2c_s1;
  logic                  r_ps2c_s2;
  logic                  r_ps2d_s1;
  logic                  r_ps2d_s2;
  logic [FILTER_LEN-1:0] r_filt_sr;
  logic                  r_filt_clk;
  logic                  r_filt_prev;
  logic [1:0]            r_state;
  logic [3:0]            r_bit_cnt;
  logic [9:0]            r_sh;
  logic [TW-1:0]         r_to_cnt;
  logic [7:0]            r_data;

  logic                  w_fall;
  logic [9:0]            w_sh_nx;
  logic                  w_frame_ok;

  // Two-flop synchronizers; reset to the idle-high bus level
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ps2c_s1 <= 1'b1;
      r_ps2c_s2 <= 1'b1;
      r_ps2d_s1 <= 1'b1;
      r_ps2d_s2 <= 1'b1;
    end else begin
      r_ps2c_s1 <= ps2c;
      r_ps2c_s2 <= r_ps2c_s1;
      r_ps2d_s1 <= ps2d;
      r_ps2d_s2 <= r_ps2d_s1;
    end
  end

  // Glitch filter: level changes only after FILTER_LEN equal samples
  always_ff @(posedge clk) begin
    if (reset) begin
      r_filt_sr   <= '1;
      r_filt_clk  <= 1'b1;
      r_filt_prev <= 1'b1;
    end else begin
      r_filt_sr   <= {r_filt_sr[FILTER_LEN-2:0], r_ps2c_s2};
      r_filt_prev <= r_filt_clk;
      if (&r_filt_sr)
        r_filt_clk <= 1'b1;
      else if (~|r_filt_sr)
        r_filt_clk <= 1'b0;
    end
  end

  assign w_fall = r_filt_prev & ~r_filt_clk;

  // Shift value after this edge: LSB-first, stop bit ends up in [9]
  assign w_sh_nx = {r_ps2d_s2, r_sh[9:1]};

  // Stop must be 1 and data+parity must hold an odd count of ones
  assign w_frame_ok = w_sh_nx[9] & (^w_sh_nx[8:0]);

  // Frame FSM with bit counter and inter-edge timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= 4'd0;
      r_sh      <= 10'd0;
      r_to_cnt  <= '0;
      r_data    <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_to_cnt <= '0;
          if (w_fall && rx_en && !r_ps2d_s2) begin
            r_state   <= S_RECV;
            r_bit_cnt <= 4'd10;
          end
        end
        S_RECV: begin
          if (w_fall) begin
            r_to_cnt  <= '0;
            r_sh      <= w_sh_nx;
            r_bit_cnt <= r_bit_cnt - 4'd1;
            if (r_bit_cnt == 4'd1) begin
              if (w_frame_ok) begin
                r_state <= S_DONE;
                r_data  <= w_sh_nx[7:0];
              end else begin
                r_state <= S_IDLE;
              end
            end
          end else if (r_to_cnt == TO_LAST) begin
            r_state   <= S_IDLE;
            r_to_cnt  <= '0;
            r_bit_cnt <= 4'd0;
          end else begin
            r_to_cnt <= r_to_cnt + TO_ONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rx_done_tick = (r_state == S_DONE);
  assign rx_data      = r_data;

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx.
// Directed frames; a negedge monitor checks every tick against a queue.
module tb_ps2_rx;

  localparam int FL   = 8;
  localparam int TO   = 500;
  localparam int HALF = 40;

  logic       clk;
  logic       reset;
  logic       rx_en;
  logic       ps2d;
  logic       ps2c;
  logic       rx_done_tick;
  logic [7:0] rx_data;

  int errors;
  int checks;
  logic [7:0] exp_q[$];

  ps2_rx #(
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_en       (rx_en),
    .ps2d        (ps2d),
    .ps2c        (ps2c),
    .rx_done_tick(rx_done_tick),
    .rx_data     (rx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every tick must match the oldest expected byte
  always @(negedge clk) begin
    if (rx_done_tick) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tick: got data %02h, required no tick",
                 rx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rx_data !== e) begin
          errors++;
          $display("FAIL tick_data: got %02h, required %02h", rx_data, e);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic send_bit(logic b);
    ps2d = b;
    cyc(HALF);
    ps2c = 1'b0;
    cyc(HALF);
    ps2c = 1'b1;
  endtask

  task automatic send_frame(logic [7:0] d, logic par, logic stp);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stp);
    ps2d = 1'b1;
    cyc(HALF);
  endtask

  // Start bit plus the first n-1 data bits, then bus idle
  task automatic send_partial(logic [7:0] d, int n);
    send_bit(1'b0);
    for (int i = 0; i < n - 1; i++) send_bit(d[i]);
    ps2d = 1'b1;
  endtask

  task automatic drain(string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      cyc(1);
      n++;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] d1c;
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    rx_en  = 1'b1;
    ps2d   = 1'b1;
    ps2c   = 1'b1;
    cyc(5);
    chk("reset_tick", rx_done_tick, 0);
    chk("reset_data", rx_data, 8'h00);
    reset = 1'b0;
    cyc(20);
    chk("idle_tick", rx_done_tick, 0);

    // 0xF0: four ones -> parity 1
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 1'b1, 1'b1);
    drain("f0_drain");
    chk("f0_hold", rx_data, 8'hF0);

    // 0x12 (parity 1) and 0x1C (parity 0) back-to-back
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h1C);
    send_frame(8'h12, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    drain("b2b_drain");
    chk("b2b_hold", rx_data, 8'h1C);

    // Bad parity, then bad stop: discarded silently
    send_frame(8'h12, 1'b0, 1'b1);
    chk("badpar_data", rx_data, 8'h1C);
    send_frame(8'h12, 1'b1, 1'b0);
    cyc(HALF);
    chk("badstop_data", rx_data, 8'h1C);

    // rx_en low for a whole frame
    rx_en = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("rxen0_data", rx_data, 8'h1C);

    // rx_en rises mid-frame after d4; later bits cannot yield a tick
    d1c = 8'h1C;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(d1c[i]);
    rx_en = 1'b1;
    for (int i = 5; i < 8; i++) send_bit(d1c[i]);
    send_bit(1'b0);
    send_bit(1'b1);
    ps2d = 1'b1;
    cyc(TO + 100);
    chk("midrx_data", rx_data, 8'h1C);

    // Following full frame is received
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1);
    drain("after_en_drain");

    // ps2c glitch of FL-1 cycles with data low, then 0x5A
    ps2d = 1'b0;
    ps2c = 1'b0;
    cyc(FL - 1);
    ps2c = 1'b1;
    cyc(HALF);
    ps2d = 1'b1;
    cyc(HALF);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b1);
    drain("glitch_drain");
    chk("glitch_data", rx_data, 8'h5A);

    // Clock stops after 5 bits: timeout, then 0xF0 still received
    send_partial(8'hF0, 5);
    cyc(TO + 100);
    chk("timeout_data", rx_data, 8'h5A);
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 1'b1, 1'b1);
    drain("timeout_drain");
    chk("timeout_next", rx_data, 8'hF0);

    // Reset mid-frame drops the partial frame
    send_partial(8'h12, 5);
    reset = 1'b1;
    cyc(3);
    chk("midrst_data", rx_data, 8'h00);
    chk("midrst_tick", rx_done_tick, 0);
    reset = 1'b0;
    cyc(HALF);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b1);
    drain("midrst_drain");
    chk("midrst_next", rx_data, 8'h5A);

    cyc(20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
